ex_sched: RTL and testbench
===========================

// Module: ex_sched
// PURPOSE
//  Shares one combinational FP32 exponential datapath (ex: S = e^A, number_exp
//  Taylor terms) between N_REQ requesters. Arbitrates round-robin, holds the
//  winner's operands stable for a SETTLE-cycle multicycle path, registers the
//  result and returns it with the requester id over a valid/ready channel.
//  Sits between the request sources and the single ex instance in the FPAU.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  IDW     2  width of rsp_id; must satisfy 2**IDW >= N_REQ
//  SETTLE  3  cycles ex_a/ex_n are held before ex_s is sampled (>=1)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   N_REQ     per-requester request valid
//  req_ready  out  N_REQ     per-requester accept (at most one bit set)
//  req_a      in   N_REQ*32  FP32 operands, requester i at [32*i+31:32*i]
//  req_n      in   N_REQ*5   term counts, requester i at [5*i+4:5*i]
//  ex_a       out  32        operand to ex.A (registered)
//  ex_n       out  5         term count to ex.number_exp (registered)
//  ex_s       in   32        result from ex.S (combinational)
//  rsp_valid  out  1         result valid
//  rsp_ready  in   1         result consumer ready
//  rsp_data   out  32        FP32 result (registered)
//  rsp_id     out  IDW       index of requester the result belongs to
//  busy       out  1         high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, cnt=0, ex_a=0, ex_n=0,
//   rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0. Reset mid-operation
//   aborts the job; no response is issued for it.
//  FSM: IDLE -> CALC -> RESP -> IDLE.
//  IDLE: winner w = first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ..
//   modulo N_REQ. req_ready[w]=1 combinationally in IDLE only; all other bits 0.
//   On the accept edge: ex_a<=req_a[w], ex_n<=req_n[w], rsp_id<=w,
//   rr_ptr<=(w+1) mod N_REQ, cnt<=SETTLE-1, state<=CALC. No valid -> stay.
//  CALC: ex_a/ex_n held constant (multicycle path to ex). cnt!=0 -> cnt-1.
//   cnt==0 -> rsp_data<=ex_s, rsp_valid<=1, state<=RESP.
//  Latency: accept at edge k -> rsp_valid high after edge k+SETTLE.
//  RESP: rsp_valid, rsp_data, rsp_id held stable until rsp_valid&rsp_ready;
//   on that edge rsp_valid<=0, state<=IDLE. No new accept in RESP or CALC
//   (req_ready=0); next accept earliest on the edge after return to IDLE.
//   Peak throughput: one job per SETTLE+2 cycles.
//  req_n passed unmodified (0 included); ex_a/ex_n keep their last value
//   outside CALC.
//  Requester dropping req_valid before accept: not granted, no side effect.
//  rr_ptr advances only on accept; sole active requester may win repeatedly.
//  All outputs glitch-free registered except req_ready and busy.
// TESTING
//  1 Reset mid-CALC (rst_n low 1 cycle, req0 A=0x3F800000, n=10 in flight) ->
//    all outputs 0, state IDLE, no response; next request completes normally.
//  2 Single req1 A=0x00000000 n=8, real ex, SETTLE=3, rsp_ready=1 ->
//    rsp_valid 3 cycles after accept, rsp_data=0x3F800000, rsp_id=1.
//  3 All four valid continuously, stub ex_s=ex_a^{27'b0,ex_n} -> grants
//    0,1,2,3,0 in order; each rsp_data matches its requester's operands.
//  4 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/data/id stable,
//    req_ready all 0, busy=1; release -> IDLE, next accept one edge later.
//  5 SETTLE=1, req2 A=0x40000000 n=31 -> rsp_valid 1 cycle after accept;
//    ex_n=31 observed unmodified; rr_ptr=3 afterwards (req3,req0 both valid ->
//    req3 wins).
//  6 req0 valid drops before IDLE (state CALC for another job) -> never
//    granted, no extra response; assertion: $onehot0(req_ready) every cycle.

Source files
------------

// File: rtl/ex_sched_if.sv
// Request/response channel between the requesters and the ex scheduler.
// The master side holds the requesters and the result consumer; the slave
// side is the scheduler.
interface ex_sched_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*5-1:0]  req_n;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;

  modport master (
    output req_valid, req_a, req_n, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_n, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/ex_sched.sv
// ex_sched: round-robin sharing of one combinational FP32 exp datapath.
// A granted job's operands are held on ex_a/ex_n for SETTLE cycles (a
// multicycle path into ex), then ex_s is captured and returned with the
// requester id over a valid/ready response channel.
module ex_sched #(
  parameter int N_REQ  = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_sched_if.slave   bus,
  output logic [31:0] ex_a,
  output logic [4:0]  ex_n,
  input  logic [31:0] ex_s,
  output logic        busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         state_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [CW-1:0]  cnt_r;
  logic [31:0]    ex_a_r;
  logic [4:0]     ex_n_r;
  logic [31:0]    rsp_data_r;
  logic [IDW-1:0] rsp_id_r;
  logic           rsp_valid_r;

  logic           found_s;
  logic [IDW-1:0] win_s;
  logic [IDW-1:0] ptr_nxt_s;
  logic [N_REQ-1:0] grant_s;
  logic [31:0]    win_a_s;
  logic [4:0]     win_n_s;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    int  idx;
    logic hit;
    found_s = 1'b0;
    win_s   = '0;
    idx     = 0;
    hit     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr_r) + i) % N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        hit     = (j == idx) && bus.req_valid[j] && !found_s;
        found_s = found_s | hit;
        win_s   = hit ? IDW'(j) : win_s;
      end
    end
  end

  // Grant decode and winner operand mux; grants are only offered in IDLE.
  always_comb begin
    logic sel;
    grant_s = '0;
    win_a_s = 32'd0;
    win_n_s = 5'd0;
    sel     = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      sel        = found_s && (win_s == IDW'(j));
      grant_s[j] = sel && (state_r == ST_IDLE);
      win_a_s    = sel ? bus.req_a[32*j +: 32] : win_a_s;
      win_n_s    = sel ? bus.req_n[5*j +: 5]   : win_n_s;
    end
    if (int'(win_s) == N_REQ - 1) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_s + IDW'(32'd1);
    end
  end

  // Job FSM: accept in IDLE, hold operands through CALC, present result in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      cnt_r       <= '0;
      ex_a_r      <= 32'd0;
      ex_n_r      <= 5'd0;
      rsp_data_r  <= 32'd0;
      rsp_id_r    <= '0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            ex_a_r   <= win_a_s;
            ex_n_r   <= win_n_s;
            rsp_id_r <= win_s;
            rr_ptr_r <= ptr_nxt_s;
            cnt_r    <= CW'(SETTLE - 1);
            state_r  <= ST_CALC;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(32'd1);
          end else begin
            rsp_data_r  <= ex_s;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign ex_a          = ex_a_r;
  assign ex_n          = ex_n_r;
  assign busy          = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ex_sched.sv
// Bench for ex_sched: directed scenarios plus randomized traffic on a
// SETTLE=3 instance checked every cycle against a job-level reference model,
// and a small SETTLE=1 instance for the short-latency case.
module tb_ex_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ex stand-in: exact e^0 = 1.0 in "real" mode, otherwise a reversible stub.
  function automatic logic [31:0] ex_ref(input logic [31:0] a, input logic [4:0] n,
                                         input logic real_m);
    if (real_m && a == 32'h0000_0000) return 32'h3F80_0000;
    return a ^ {27'd0, n};
  endfunction

  // ---------------- SETTLE=3 instance ----------------
  logic        rst_n3 = 1'b0;
  logic        real_mode = 1'b0;
  logic [31:0] ex_a3, ex_s3;
  logic [4:0]  ex_n3;
  logic        busy3;
  ex_sched_if #(.N_REQ(4), .IDW(2)) if3 ();
  assign ex_s3 = ex_ref(ex_a3, ex_n3, real_mode);

  ex_sched #(.N_REQ(4), .IDW(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .bus(if3.slave),
    .ex_a(ex_a3), .ex_n(ex_n3), .ex_s(ex_s3), .busy(busy3)
  );

  // ---------------- SETTLE=1 instance ----------------
  logic        rst_n1 = 1'b0;
  logic [31:0] ex_a1, ex_s1;
  logic [4:0]  ex_n1;
  logic        busy1;
  ex_sched_if #(.N_REQ(4), .IDW(2)) if1 ();
  assign ex_s1 = ex_ref(ex_a1, ex_n1, 1'b0);

  ex_sched #(.N_REQ(4), .IDW(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .bus(if1.slave),
    .ex_a(ex_a1), .ex_n(ex_n1), .ex_s(ex_s1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // At most one grant per cycle on both instances.
  always @(negedge clk) begin
    checks++;
    assert ($onehot0(if3.req_ready) && $onehot0(if1.req_ready)) else begin
      errors++;
      $error("FAIL onehot0 observed=%b/%b expected=onehot0", if3.req_ready, if1.req_ready);
    end
  end

  // Job-level reference model: 0 idle, 1 computing, 2 holding a response.
  localparam int SETTLE3 = 3;
  int          m_state, m_ptr, m_wait, m_id;
  logic [31:0] m_a, m_data;
  logic [4:0]  m_n;
  int          dut_grants[$];

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_wait = 0; m_id = 0;
    m_a = 32'd0; m_n = 5'd0; m_data = 32'd0;
  endtask

  // One clock of the SETTLE=3 instance: check at negedge, advance model at posedge.
  task automatic step3();
    int w;
    logic [3:0] er;
    @(negedge clk);
    w = -1;
    if (m_state == 0) begin
      for (int i = 0; i < 4; i++) begin
        int j;
        j = (m_ptr + i) % 4;
        if (w < 0 && if3.req_valid[j]) w = j;
      end
    end
    er = 4'b0000;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(if3.req_ready), 32'(er));
    chk("busy",      32'(busy3),         (m_state != 0) ? 32'd1 : 32'd0);
    chk("rsp_valid", 32'(if3.rsp_valid), (m_state == 2) ? 32'd1 : 32'd0);
    chk("rsp_data",  if3.rsp_data,       m_data);
    chk("rsp_id",    32'(if3.rsp_id),    32'(m_id));
    chk("ex_a",      ex_a3,              m_a);
    chk("ex_n",      32'(ex_n3),         32'(m_n));
    for (int i = 0; i < 4; i++) if (if3.req_ready[i]) dut_grants.push_back(i);
    @(posedge clk);
    if (rst_n3) begin
      case (m_state)
        0: if (w >= 0) begin
             m_a = if3.req_a[32*w +: 32];
             m_n = if3.req_n[5*w +: 5];
             m_id = w; m_ptr = (w + 1) % 4; m_wait = SETTLE3; m_state = 1;
           end
        1: begin
             m_wait--;
             if (m_wait == 0) begin m_data = ex_ref(m_a, m_n, real_mode); m_state = 2; end
           end
        2: if (if3.rsp_ready) m_state = 0;
        default: m_state = 0;
      endcase
    end
    #1;
  endtask

  task automatic reset3();
    if3.req_valid = 4'b0000;
    rst_n3 = 1'b0;
    model_reset();
    step3();
    rst_n3 = 1'b1;
  endtask

  // Raise one request until the model sees it accepted, then drop it.
  task automatic issue(input int r, input logic [31:0] a, input logic [4:0] n);
    int k;
    if3.req_a[32*r +: 32] = a;
    if3.req_n[5*r +: 5]   = n;
    if3.req_valid[r]      = 1'b1;
    k = 0;
    while (!(m_state == 1 && m_id == r) && k < 40) begin step3(); k++; end
    if (k >= 40) chk("accept_timeout", 32'd0, 32'd1);
    if3.req_valid[r] = 1'b0;
  endtask

  task automatic run_idle();
    int k;
    k = 0;
    while (m_state != 0 && k < 60) begin step3(); k++; end
    if (k >= 60) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic latency_check(input string tag);
    int lat;
    lat = 0;
    while (!if3.rsp_valid && lat < 20) begin step3(); lat++; end
    chk(tag, 32'(lat), 32'd3);
  endtask

  initial begin
    int exp_g[5];
    if3.req_valid = 4'b0; if3.req_a = '0; if3.req_n = '0; if3.rsp_ready = 1'b1;
    if1.req_valid = 4'b0; if1.req_a = '0; if1.req_n = '0; if1.rsp_ready = 1'b1;
    model_reset();

    // Reset state.
    reset3();
    step3();

    // Abort mid-CALC by reset; no response for the aborted job.
    issue(0, 32'h3F80_0000, 5'd10);
    step3();
    rst_n3 = 1'b0;
    model_reset();
    step3();
    rst_n3 = 1'b1;
    repeat (5) step3();
    issue(0, 32'h3F80_0000, 5'd10);
    latency_check("latency_after_reset");
    run_idle();

    // Single real-mode job: e^0 = 1.0 returned to requester 1.
    real_mode = 1'b1;
    issue(1, 32'h0000_0000, 5'd8);
    latency_check("latency_req1");
    chk("exp_zero_data", if3.rsp_data, 32'h3F80_0000);
    chk("exp_zero_id",   32'(if3.rsp_id), 32'd1);
    run_idle();
    real_mode = 1'b0;

    // All four continuously valid from reset: grants rotate 0,1,2,3,0.
    reset3();
    dut_grants.delete();
    for (int i = 0; i < 4; i++) begin
      if3.req_a[32*i +: 32] = 32'hA5A5_0000 + 32'(i * 32'h111);
      if3.req_n[5*i +: 5]   = 5'(3 * i + 1);
    end
    if3.req_valid = 4'b1111;
    repeat (22) step3();
    if3.req_valid = 4'b0000;
    run_idle();
    exp_g = '{0, 1, 2, 3, 0};
    chk("grant_count", (dut_grants.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5 && i < dut_grants.size(); i++)
      chk($sformatf("grant_%0d", i), 32'(dut_grants[i]), 32'(exp_g[i]));

    // Back-pressure: response held 10 cycles with all requesters waiting.
    if3.rsp_ready = 1'b0;
    issue(2, 32'h1234_5678, 5'd17);
    begin
      int k;
      k = 0;
      while (m_state != 2 && k < 20) begin step3(); k++; end
    end
    if3.req_valid = 4'b1111;
    repeat (10) step3();
    if3.rsp_ready = 1'b1;
    step3();
    step3();
    chk("accept_after_release", 32'(m_state), 32'd1);
    if3.req_valid = 4'b0000;
    run_idle();

    // Requester 0 raises and drops valid while another job is in CALC.
    issue(1, 32'h0BAD_F00D, 5'd5);
    if3.req_a[31:0] = 32'hDEAD_BEEF;
    if3.req_valid[0] = 1'b1;
    step3();
    if3.req_valid[0] = 1'b0;
    run_idle();
    repeat (6) step3();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if3.req_a[32*i +: 32] = $urandom;
        if3.req_n[5*i +: 5]   = 5'($urandom_range(0, 31));
      end
      if3.req_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if3.rsp_ready = ($urandom_range(0, 9) < 7);
      step3();
    end
    if3.req_valid = 4'b0000;
    if3.rsp_ready = 1'b1;
    run_idle();
    step3();

    // SETTLE=1: one-cycle latency, n=31 unmodified, pointer moves to 3.
    @(negedge clk);
    chk("s1_reset_valid", 32'(if1.rsp_valid), 32'd0);
    chk("s1_reset_busy",  32'(busy1),         32'd0);
    @(posedge clk); #1;
    rst_n1 = 1'b1;
    if1.req_a[64 +: 32] = 32'h4000_0000;
    if1.req_n[10 +: 5]  = 5'd31;
    if1.req_valid = 4'b0100;
    @(negedge clk);
    chk("s1_ready", 32'(if1.req_ready), 32'h4);
    @(posedge clk); #1;
    if1.req_valid = 4'b0000;
    chk("s1_ex_n",  32'(ex_n1), 32'd31);
    chk("s1_ex_a",  ex_a1,      32'h4000_0000);
    chk("s1_busy",  32'(busy1), 32'd1);
    chk("s1_valid_early", 32'(if1.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("s1_valid", 32'(if1.rsp_valid), 32'd1);
    chk("s1_data",  if1.rsp_data, ex_ref(32'h4000_0000, 5'd31, 1'b0));
    chk("s1_id",    32'(if1.rsp_id), 32'd2);
    @(posedge clk); #1;
    if1.req_valid = 4'b1001;
    @(negedge clk);
    chk("s1_rr_ptr3", 32'(if1.req_ready), 32'h8);
    @(posedge clk); #1;
    if1.req_valid = 4'b0000;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
